// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the scan-sniffing decoder.
// Segment order is seg[6]=a down to seg[0]=g, active-high.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A_HEX = 7'b1110111;
  localparam logic [6:0] SEG_B_HEX = 7'b0011111;
  localparam logic [6:0] SEG_C_HEX = 7'b1001110;
  localparam logic [6:0] SEG_D_HEX = 7'b0111101;
  localparam logic [6:0] SEG_E_HEX = 7'b1001111;
  localparam logic [6:0] SEG_F_HEX = 7'b1000111;

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Unrecognised patterns flag bad and return nibble 0.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       bad_o,
  output logic [3:0] nib_o
);

  always_comb begin
    bad_o = 1'b0;
    nib_o = 4'h0;
    case (seg_i)
      SEG_0:     nib_o = 4'h0;
      SEG_1:     nib_o = 4'h1;
      SEG_2:     nib_o = 4'h2;
      SEG_3:     nib_o = 4'h3;
      SEG_4:     nib_o = 4'h4;
      SEG_5:     nib_o = 4'h5;
      SEG_6:     nib_o = 4'h6;
      SEG_7:     nib_o = 4'h7;
      SEG_8:     nib_o = 4'h8;
      SEG_9:     nib_o = 4'h9;
      SEG_A_HEX: nib_o = 4'hA;
      SEG_B_HEX: nib_o = 4'hB;
      SEG_C_HEX: nib_o = 4'hC;
      SEG_D_HEX: nib_o = 4'hD;
      SEG_E_HEX: nib_o = 4'hE;
      SEG_F_HEX: nib_o = 4'hF;
      default:   bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex frame shown on a multiplexed seven-segment bus,
// filtering scan glitches and flagging unrecognised digit patterns.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        seg,
  output logic [4*NDIG-1:0] value,
  output logic              valid,
  output logic [NDIG-1:0]   bad_mask,
  output logic              err
);

  localparam int SW = NDIG + 7;
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE);
  localparam logic [CW-1:0] CACC = CW'(STABLE - 1);

  logic [SW-1:0]     pins;
  logic [SW-1:0]     sample_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NDIG-1:0]   an_s;
  logic              same;
  logic              acc;
  logic              dec_bad;
  logic [3:0]        dec_nib;
  logic [NDIG-1:0]   cap_q, cap_d;
  logic [NDIG-1:0]   bad_q;
  logic [4*NDIG-1:0] nib_q;
  logic [4*NDIG-1:0] value_q;
  logic [NDIG-1:0]   mask_q;
  logic              err_q;
  logic              valid_q;
  state_e            state_q;

  assign pins = {an, seg};
  assign an_s = sample_q[SW-1:7];

  seg7_to_hex u_dec (
    .seg_i (sample_q[6:0]),
    .bad_o (dec_bad),
    .nib_o (dec_nib)
  );

  // sample_q is the previous sample relative to the pins being registered
  always_comb begin
    same  = (pins == sample_q);
    cnt_d = CW'(1);
    if (same)
      cnt_d = (cnt_q == CMAX) ? CMAX : cnt_q + CW'(1);
    acc   = same && (cnt_q == CACC) && $onehot(an_s);
    cap_d = cap_q | (acc ? an_s : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      cnt_q    <= '0;
      cap_q    <= '0;
      bad_q    <= '0;
      nib_q    <= '0;
      value_q  <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      state_q  <= COLLECT;
    end else begin
      sample_q <= pins;
      cnt_q    <= cnt_d;
      valid_q  <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          if (acc) begin
            for (int i = 0; i < NDIG; i++) begin
              if (an_s[i]) begin
                nib_q[4*i +: 4] <= dec_nib;
                bad_q[i]        <= dec_bad;
              end
            end
          end
          cap_q <= cap_d;
          if (&cap_d)
            state_q <= PUBLISH;
        end
        PUBLISH: begin
          value_q <= nib_q;
          mask_q  <= bad_q;
          err_q   <= |bad_q;
          valid_q <= 1'b1;
          cap_q   <= '0;
          bad_q   <= '0;
          state_q <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign value    = value_q;
  assign valid    = valid_q;
  assign bad_mask = mask_q;
  assign err      = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge
// monitor pops and checks each valid pulse including its timing.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = '0;
  logic [6:0]  seg = '0;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  bad_mask;
  logic        err;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PA = 7'b1110111;
  localparam logic [6:0] PB = 7'b0011111;
  localparam logic [6:0] PC = 7'b1001110;
  localparam logic [6:0] PD = 7'b0111101;
  localparam logic [6:0] PE = 7'b1001111;
  localparam logic [6:0] PF = 7'b1000111;
  localparam logic [6:0] PX = 7'b0000001;

  seg7_scan_decoder #(.NDIG(4), .STABLE(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .an       (an),
    .seg      (seg),
    .value    (value),
    .valid    (valid),
    .bad_mask (bad_mask),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  m;
    logic        e;
    int          c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;
  int pulses = 0;
  int cyc    = 0;
  bit vprev  = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      pulses++;
      chk("valid_gap", 32'(vprev), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got value %0h expected none",
                 value);
      end else begin
        e = sb.pop_front();
        chk("value", 32'(value), 32'(e.v));
        chk("bad_mask", 32'(bad_mask), 32'(e.m));
        chk("err", 32'(err), 32'(e.e));
        chk("pulse_cycle", 32'(cyc), 32'(e.c));
      end
    end
    vprev = valid;
  end

  // entered just after a rising edge; pins change now
  task automatic hold(input logic [3:0] a, input logic [6:0] s,
                      input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pulse expected 4 edges after the final digit is driven
  task automatic expect_frame(input logic [15:0] v, input logic [3:0] m,
                              input logic e);
    exp_t x;
    x.v = v;
    x.m = m;
    x.e = e;
    x.c = cyc + 4;
    sb.push_back(x);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3,
                      input logic [15:0] v, input logic [3:0] m,
                      input logic e);
    hold(4'b0001, s0, 4);
    hold(4'b0010, s1, 4);
    hold(4'b0100, s2, 4);
    expect_frame(v, m, e);
    hold(4'b1000, s3, 4);
    hold(4'b0000, 7'd0, 6);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_value"}, 32'(value), 32'd0);
    chk({tag, "_mask"}, 32'(bad_mask), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    hold(4'b0000, 7'd0, 4);

    scan(PF, P0, PA, P3, 16'h3A0F, 4'b0000, 1'b0);

    hold(4'b0001, PF, 4);
    hold(4'b0010, P1, 2);
    hold(4'b0010, P0, 4);
    hold(4'b0100, PA, 4);
    expect_frame(16'h3A0F, 4'b0000, 1'b0);
    hold(4'b1000, P3, 4);
    hold(4'b0000, 7'd0, 6);

    scan(PF, P0, PX, P3, 16'h300F, 4'b0100, 1'b1);

    hold(4'b0001, PF, 4);
    hold(4'b0000, P8(), 5);
    hold(4'b0010, P0, 4);
    hold(4'b0011, P4, 5);
    hold(4'b0100, PA, 4);
    hold(4'b0000, 7'd0, 5);
    expect_frame(16'h3A0F, 4'b0000, 1'b0);
    hold(4'b1000, P3, 4);
    hold(4'b0000, 7'd0, 6);

    hold(4'b0001, P5, 4);
    scan(P9, P0, PA, P3, 16'h3A09, 4'b0000, 1'b0);

    hold(4'b0001, P7, 4);
    hold(4'b0010, PE, 4);
    rst = 1'b1;
    hold(4'b0000, 7'd0, 2);
    chk_zero("midrst");
    rst = 1'b0;
    hold(4'b0000, 7'd0, 3);
    hold(4'b0100, PD, 4);
    hold(4'b1000, PC, 4);
    hold(4'b0001, PB, 4);
    expect_frame(16'hCD4B, 4'b0000, 1'b0);
    hold(4'b0010, P4, 4);

    hold(4'b0000, 7'd0, 20);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("pulse_count", 32'(pulses), 32'd6);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  function automatic logic [6:0] P8();
    return 7'b1111111;
  endfunction

endmodule
